// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath (fetch/decode/exec/mem/wb).
// Defining RISC_CTRL_TIMEOUT_EN adds a bus-timeout watchdog that halts with a sticky err.
module risc_ctrl_fsm #(
  parameter int W       = 16,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [W-1:0]  mem_rdata,
  input  logic          alu_zero,
  output logic [W-1:0]  ir,
  output logic [AW-1:0] PC_addr,
  output logic [2:0]    alu_s,
  output logic          reg_we,
  output logic          wb_sel,
  output logic [2:0]    state,
  output logic [2:0]    nstate,
  output logic          halted,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [W-1:0]  ir_q, ir_d;
  logic [3:0]    opcode;
  logic          is_alu, is_nop;

  assign opcode = ir_q[W-1:W-4];
  assign is_alu = ~opcode[3];
  assign is_nop = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);

`ifdef RISC_CTRL_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case so no path infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    alu_s    = 3'd0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HLT) state_d = S_HALT;
        else if (is_nop)      state_d = S_FETCH;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_s = ir_q[W-2:W-4];
        if (is_alu) begin
          state_d = S_WB;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          if (opcode == OP_JMP || (opcode == OP_BEQ && alu_zero)) pc_d = ir_q[AW-1:0];
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_ST);
        mem_addr = ir_q[AW-1:0];
        if (mem_ack) state_d = (opcode == OP_ST) ? S_FETCH : S_WB;
      end
      S_WB: begin
        alu_s   = ir_q[W-2:W-4];
        reg_we  = 1'b1;
        wb_sel  = (opcode == OP_LD);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

`ifdef RISC_CTRL_TIMEOUT_EN
    // Counter is zero whenever a handshake is not stalling, so entry to FETCH/MEM starts at 0.
    wait_cnt_d = '0;
    err_d      = err_q;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack) begin
      if (wait_cnt_q == 4'(TIMEOUT - 1)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef RISC_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign err            = 1'b0;
`endif

  assign state   = state_q;
  assign nstate  = state_d;
  assign ir      = ir_q;
  assign PC_addr = pc_q;
  assign halted  = (state_q == S_HALT);

endmodule
